// File: rtl/core_pixel_mover.sv
// Byte-addressed fill/move/drain stage for one 8x8 RGB pixel set (192 bytes).
// Addresses come from the companion core_pixel generator, advanced by the step strobes.
module core_pixel_mover (
    input  logic        I_HCLK,
    input  logic        I_HRESET_N,
    input  logic        I_START,
    input  logic        I_DMA_READY,
    input  logic [31:0] I_WDATA,
    input  logic        I_WVALID,
    output logic        O_WREADY,
    input  logic [7:0]  I_PIXEL_IN_ADDR0,
    input  logic [7:0]  I_PIXEL_IN_ADDR1,
    input  logic [7:0]  I_PIXEL_IN_ADDR2,
    input  logic [7:0]  I_PIXEL_IN_ADDR3,
    input  logic [7:0]  I_PIXEL_IN_ADDRR,
    input  logic [7:0]  I_PIXEL_IN_ADDRG,
    input  logic [7:0]  I_PIXEL_IN_ADDRB,
    input  logic [7:0]  I_PIXEL_OUT_ADDRR,
    input  logic [7:0]  I_PIXEL_OUT_ADDRG,
    input  logic [7:0]  I_PIXEL_OUT_ADDRB,
    input  logic [7:0]  I_PIXEL_OUT_ADDR0,
    input  logic [7:0]  I_PIXEL_OUT_ADDR1,
    input  logic [7:0]  I_PIXEL_OUT_ADDR2,
    input  logic [7:0]  I_PIXEL_OUT_ADDR3,
    output logic [31:0] O_RDATA,
    output logic        O_RVALID,
    input  logic        I_RREADY,
    output logic        O_FILL_STEP,
    output logic        O_MOVE_STEP,
    output logic        O_DRAIN_STEP,
    output logic        O_BUSY,
    output logic        O_DONE
);

    localparam int DATA_W    = 8;
    localparam int BUF_BYTES = 192;
    localparam int WORDS     = 48;
    localparam int PIXELS    = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_MOVE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] in_mem  [0:BUF_BYTES-1];
    logic [DATA_W-1:0] out_mem [0:BUF_BYTES-1];

    logic [5:0]  fill_cnt;
    logic [5:0]  pix_cnt;
    logic [5:0]  load_cnt;
    logic        fill_hs;
    logic        drain_load;
    logic        drain_acc;
    logic [31:0] rdata_p1;
    logic        vld_p1;

    logic [7:0]        fill_addr [0:3];
    logic [DATA_W-1:0] mv_r, mv_g, mv_b;

    function automatic logic in_range(input logic [7:0] addr);
        return addr < 8'(BUF_BYTES);
    endfunction

    // Out-of-range reads return zero instead of touching the array.
    function automatic logic [DATA_W-1:0] in_rd(input logic [7:0] addr);
        return in_range(addr) ? in_mem[addr] : '0;
    endfunction

    function automatic logic [DATA_W-1:0] out_rd(input logic [7:0] addr);
        return in_range(addr) ? out_mem[addr] : '0;
    endfunction

    assign fill_addr[0] = I_PIXEL_IN_ADDR0;
    assign fill_addr[1] = I_PIXEL_IN_ADDR1;
    assign fill_addr[2] = I_PIXEL_IN_ADDR2;
    assign fill_addr[3] = I_PIXEL_IN_ADDR3;

    assign mv_r = in_rd(I_PIXEL_IN_ADDRR);
    assign mv_g = in_rd(I_PIXEL_IN_ADDRG);
    assign mv_b = in_rd(I_PIXEL_IN_ADDRB);

    assign drain_acc = vld_p1 & I_RREADY;
    assign O_RDATA   = rdata_p1;
    assign O_RVALID  = vld_p1;

    always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
        if (!I_HRESET_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (I_START) state_nxt = S_FILL;
            S_FILL:  if (fill_hs && fill_cnt == 6'(WORDS - 1)) state_nxt = S_MOVE;
            S_MOVE:  if (pix_cnt == 6'(PIXELS - 1)) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_acc && load_cnt == 6'(WORDS)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        O_WREADY    = (state == S_FILL) & I_DMA_READY;
        fill_hs     = O_WREADY & I_WVALID;
        O_MOVE_STEP = (state == S_MOVE);
        drain_load  = (state == S_DRAIN) & (~vld_p1 | I_RREADY) & I_DMA_READY
                      & (load_cnt < 6'(WORDS));
        O_BUSY      = (state != S_IDLE);
        O_DONE      = (state == S_DONE);
    end

    assign O_FILL_STEP  = fill_hs;
    assign O_DRAIN_STEP = drain_load;

    // Counters are held clear in IDLE so every set starts from zero.
    always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
        if (!I_HRESET_N) begin
            fill_cnt <= '0;
            pix_cnt  <= '0;
            load_cnt <= '0;
        end else if (state == S_IDLE) begin
            fill_cnt <= '0;
            pix_cnt  <= '0;
            load_cnt <= '0;
        end else begin
            if (fill_hs)          fill_cnt <= fill_cnt + 6'd1;
            if (state == S_MOVE)  pix_cnt  <= pix_cnt + 6'd1;
            if (drain_load)       load_cnt <= load_cnt + 6'd1;
        end
    end

    // Fill stage: later lanes overwrite earlier ones on duplicate addresses.
    always_ff @(posedge I_HCLK) begin
        if (fill_hs) begin
            for (int k = 0; k < 4; k++) begin
                if (in_range(fill_addr[k])) in_mem[fill_addr[k]] <= I_WDATA[8*k +: 8];
            end
        end
    end

    // Move stage: write order R, G, B so B wins a shared address.
    always_ff @(posedge I_HCLK) begin
        if (state == S_MOVE) begin
            if (in_range(I_PIXEL_OUT_ADDRR)) out_mem[I_PIXEL_OUT_ADDRR] <= mv_r;
            if (in_range(I_PIXEL_OUT_ADDRG)) out_mem[I_PIXEL_OUT_ADDRG] <= mv_g;
            if (in_range(I_PIXEL_OUT_ADDRB)) out_mem[I_PIXEL_OUT_ADDRB] <= mv_b;
        end
    end

    // Drain stage: one registered word, held while the consumer stalls.
    always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
        if (!I_HRESET_N) begin
            rdata_p1 <= '0;
            vld_p1   <= 1'b0;
        end else if (drain_load) begin
            rdata_p1 <= {out_rd(I_PIXEL_OUT_ADDR3), out_rd(I_PIXEL_OUT_ADDR2),
                         out_rd(I_PIXEL_OUT_ADDR1), out_rd(I_PIXEL_OUT_ADDR0)};
            vld_p1   <= 1'b1;
        end else if (drain_acc) begin
            vld_p1   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_core_pixel_mover.sv
// Bench for core_pixel_mover: plays the core_pixel address generator and the DMA side,
// checks control vectors and whole-set data against a byte-buffer reference model.
module tb_core_pixel_mover;

    logic        I_HCLK = 1'b0;
    logic        I_HRESET_N = 1'b0;
    logic        I_START = 1'b0;
    logic        I_DMA_READY = 1'b0;
    logic [31:0] I_WDATA = '0;
    logic        I_WVALID = 1'b0;
    logic        I_RREADY = 1'b0;
    logic        O_WREADY, O_RVALID, O_FILL_STEP, O_MOVE_STEP, O_DRAIN_STEP, O_BUSY, O_DONE;
    logic [31:0] O_RDATA;

    logic [7:0] fa [0:3];
    logic [7:0] da [0:3];
    logic [7:0] mi [0:2];
    logic [7:0] mo [0:2];

    logic [7:0] fill_tab [0:191];
    logic [7:0] dr_tab   [0:191];
    logic [7:0] mv_in    [0:2][0:63];
    logic [7:0] mv_out   [0:2][0:63];

    int fcnt = 0, mcnt = 0, dcnt = 0;
    int total = 0, bad = 0;

    logic [7:0]  in_m  [0:191];
    logic [7:0]  out_m [0:191];
    logic [31:0] fw    [0:47];
    logic [31:0] expw  [0:47];
    logic [31:0] got   [$];

    int r_done_cyc, r_first_rv, r_nfs, r_nms, r_nds, r_ndone, r_unstable;

    typedef struct packed {
        logic start, dma, wv, rr;
        logic e_wready, e_fstep, e_busy, e_done;
    } vec_t;
    vec_t vecs [0:7];

    core_pixel_mover dut (
        .I_HCLK(I_HCLK), .I_HRESET_N(I_HRESET_N), .I_START(I_START),
        .I_DMA_READY(I_DMA_READY), .I_WDATA(I_WDATA), .I_WVALID(I_WVALID),
        .O_WREADY(O_WREADY),
        .I_PIXEL_IN_ADDR0(fa[0]), .I_PIXEL_IN_ADDR1(fa[1]),
        .I_PIXEL_IN_ADDR2(fa[2]), .I_PIXEL_IN_ADDR3(fa[3]),
        .I_PIXEL_IN_ADDRR(mi[0]), .I_PIXEL_IN_ADDRG(mi[1]), .I_PIXEL_IN_ADDRB(mi[2]),
        .I_PIXEL_OUT_ADDRR(mo[0]), .I_PIXEL_OUT_ADDRG(mo[1]), .I_PIXEL_OUT_ADDRB(mo[2]),
        .I_PIXEL_OUT_ADDR0(da[0]), .I_PIXEL_OUT_ADDR1(da[1]),
        .I_PIXEL_OUT_ADDR2(da[2]), .I_PIXEL_OUT_ADDR3(da[3]),
        .O_RDATA(O_RDATA), .O_RVALID(O_RVALID), .I_RREADY(I_RREADY),
        .O_FILL_STEP(O_FILL_STEP), .O_MOVE_STEP(O_MOVE_STEP), .O_DRAIN_STEP(O_DRAIN_STEP),
        .O_BUSY(O_BUSY), .O_DONE(O_DONE)
    );

    always #5 I_HCLK = ~I_HCLK;

    // Address generator stand-in: each stream advances on its strobe, restarts when idle.
    always_ff @(posedge I_HCLK) begin
        if (!O_BUSY) begin
            fcnt <= 0;
            mcnt <= 0;
            dcnt <= 0;
        end else begin
            if (O_FILL_STEP)  fcnt <= fcnt + 1;
            if (O_MOVE_STEP)  mcnt <= mcnt + 1;
            if (O_DRAIN_STEP) dcnt <= dcnt + 1;
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            fa[k] = (fcnt < 48) ? fill_tab[fcnt*4+k] : 8'd0;
            da[k] = (dcnt < 48) ? dr_tab[dcnt*4+k] : 8'd0;
        end
        for (int c = 0; c < 3; c++) begin
            mi[c] = (mcnt < 64) ? mv_in[c][mcnt] : 8'd0;
            mo[c] = (mcnt < 64) ? mv_out[c][mcnt] : 8'd0;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ctl_bits();
        return {25'd0, O_WREADY, O_RVALID, O_FILL_STEP, O_MOVE_STEP, O_DRAIN_STEP, O_BUSY, O_DONE};
    endfunction

    task automatic set_through();
        for (int i = 0; i < 192; i++) begin
            fill_tab[i] = 8'(i);
            dr_tab[i]   = 8'(i);
        end
        for (int p = 0; p < 64; p++)
            for (int c = 0; c < 3; c++) begin
                mv_in[c][p]  = 8'(3*p + c);
                mv_out[c][p] = 8'(3*p + c);
            end
    endtask

    // Byte-level picture of one set: sequential fill, sequential R/G/B move, then drain.
    task automatic model_set();
        logic [7:0] a, v;
        for (int w = 0; w < 48; w++)
            for (int k = 0; k < 4; k++) begin
                a = fill_tab[4*w+k];
                if (a < 8'd192) in_m[a] = fw[w][8*k +: 8];
            end
        for (int p = 0; p < 64; p++)
            for (int c = 0; c < 3; c++) begin
                a = mv_in[c][p];
                v = (a < 8'd192) ? in_m[a] : 8'd0;
                a = mv_out[c][p];
                if (a < 8'd192) out_m[a] = v;
            end
        for (int w = 0; w < 48; w++)
            for (int k = 0; k < 4; k++) begin
                a = dr_tab[4*w+k];
                expw[w][8*k +: 8] = (a < 8'd192) ? out_m[a] : 8'd0;
            end
    endtask

    task automatic random_words();
        for (int w = 0; w < 48; w++) fw[w] = $urandom() | 32'h1;
    endtask

    task automatic compare_words(input string nm);
        check({nm, "_count"}, 32'(got.size()), 32'd48);
        for (int w = 0; w < 48 && w < got.size(); w++)
            check($sformatf("%s_word%0d", nm, w), got[w], expw[w]);
    endtask

    task automatic run_set(input bit rnd, input bit spur, input int rst_pix, input string nm);
        int widx;
        bit prev_stall, spur_fired;
        logic [31:0] prev_data;
        got.delete();
        widx = 0; prev_stall = 0; spur_fired = 0; prev_data = '0;
        r_done_cyc = -1; r_first_rv = -1;
        r_nfs = 0; r_nms = 0; r_nds = 0; r_ndone = 0; r_unstable = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge I_HCLK);
            I_START = (cyc == 0);
            if (spur && !spur_fired && r_nms == 10) begin
                I_START = 1'b1;
                spur_fired = 1;
            end
            if (rnd) begin
                I_DMA_READY = 1'($urandom_range(0, 1));
                I_WVALID    = 1'($urandom_range(0, 1));
                I_RREADY    = 1'($urandom_range(0, 1));
            end else begin
                I_DMA_READY = 1'b1;
                I_WVALID    = 1'b1;
                I_RREADY    = 1'b1;
            end
            I_WDATA = (widx < 48) ? fw[widx] : 32'hDEAD_BEEF;
            #1;
            if (prev_stall && (!O_RVALID || O_RDATA !== prev_data)) r_unstable++;
            prev_stall = O_RVALID && !I_RREADY;
            prev_data  = O_RDATA;
            if (O_FILL_STEP) begin
                r_nfs++;
                widx++;
            end
            if (O_MOVE_STEP)  r_nms++;
            if (O_DRAIN_STEP) r_nds++;
            if (O_RVALID && r_first_rv < 0) r_first_rv = cyc;
            if (O_RVALID && I_RREADY) got.push_back(O_RDATA);
            if (O_DONE) begin
                r_ndone++;
                if (r_done_cyc < 0) r_done_cyc = cyc;
            end
            if (rst_pix >= 0 && r_nms == rst_pix) begin
                I_START = 1'b0;
                #1 I_HRESET_N = 1'b0;
                #1;
                check({nm, "_reset_ctl"}, ctl_bits(), 32'd0);
                check({nm, "_reset_rdata"}, O_RDATA, 32'd0);
                @(negedge I_HCLK);
                @(negedge I_HCLK);
                I_HRESET_N = 1'b1;
                return;
            end
            if (r_done_cyc >= 0 && cyc >= r_done_cyc + 6) break;
        end
        I_START = 1'b0;
        check({nm, "_finished"}, 32'(r_done_cyc >= 0), 32'd1);
    endtask

    initial begin
        set_through();

        repeat (3) @(negedge I_HCLK);
        #1;
        check("por_ctl", ctl_bits(), 32'd0);
        check("por_rdata", O_RDATA, 32'd0);
        @(negedge I_HCLK);
        I_HRESET_N = 1'b1;

        // IDLE then FILL control behaviour; columns: start dma wv rr | wready fstep busy done
        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            @(negedge I_HCLK);
            I_START = vecs[i].start; I_DMA_READY = vecs[i].dma;
            I_WVALID = vecs[i].wv; I_RREADY = vecs[i].rr;
            I_WDATA = $urandom();
            #1;
            check($sformatf("vec%0d_wready", i), 32'(O_WREADY), 32'(vecs[i].e_wready));
            check($sformatf("vec%0d_fstep", i), 32'(O_FILL_STEP), 32'(vecs[i].e_fstep));
            check($sformatf("vec%0d_busy", i), 32'(O_BUSY), 32'(vecs[i].e_busy));
            check($sformatf("vec%0d_done", i), 32'(O_DONE), 32'(vecs[i].e_done));
        end

        // Reset while in FILL with the handshake inputs asserted.
        @(negedge I_HCLK);
        I_START = 1'b0; I_DMA_READY = 1'b1; I_WVALID = 1'b1;
        #1;
        check("fill_before_reset_wready", 32'(O_WREADY), 32'd1);
        I_HRESET_N = 1'b0;
        #1;
        check("fill_reset_ctl", ctl_bits(), 32'd0);
        @(negedge I_HCLK);
        I_HRESET_N = 1'b1;

        for (int w = 0; w < 48; w++) fw[w] = 32'h0302_0100 + 32'(w) * 32'h0404_0404;
        set_through();
        model_set();
        run_set(0, 0, -1, "through");
        check("through_first_rvalid", 32'(r_first_rv), 32'd114);
        check("through_done_cycle", 32'(r_done_cyc), 32'd162);
        check("through_word0", (got.size() > 0) ? got[0] : 32'hX, 32'h0302_0100);
        compare_words("through");

        for (int i = 0; i < 192; i++) fw[i/4][8*(i%4) +: 8] = 8'((i/3) + 64*(i%3));
        set_through();
        for (int p = 0; p < 64; p++)
            for (int c = 0; c < 3; c++) mv_out[c][p] = 8'(3*((p%8)*8 + p/8) + c);
        model_set();
        run_set(0, 0, -1, "rot90");
        check("rot90_px1_r", (got.size() > 6) ? 32'(got[6][7:0]) : 32'hX, 32'd1);
        check("rot90_px8_r", (got.size() > 0) ? 32'(got[0][31:24]) : 32'hX, 32'd8);
        check("rot90_px8_b", (got.size() > 1) ? 32'(got[1][15:8]) : 32'hX, 32'd136);
        compare_words("rot90");

        random_words();
        set_through();
        model_set();
        run_set(1, 0, -1, "bp");
        check("bp_fill_steps", 32'(r_nfs), 32'd48);
        check("bp_move_steps", 32'(r_nms), 32'd64);
        check("bp_drain_steps", 32'(r_nds), 32'd48);
        check("bp_rdata_stable", 32'(r_unstable), 32'd0);
        check("bp_done_pulses", 32'(r_ndone), 32'd1);
        compare_words("bp");

        random_words();
        set_through();
        dr_tab[0] = 8'd200;
        model_set();
        run_set(0, 0, -1, "oor_drain");
        check("oor_drain_byte0", (got.size() > 0) ? 32'(got[0][7:0]) : 32'hX, 32'd0);
        compare_words("oor_drain");

        // Fill attempts while idle must be refused and leave the input buffer alone.
        set_through();
        for (int i = 0; i < 4; i++) begin
            @(negedge I_HCLK);
            I_START = 1'b0; I_DMA_READY = 1'b1; I_WVALID = 1'b1; I_WDATA = $urandom();
            #1;
            check($sformatf("idle_wvalid%0d_ctl", i), ctl_bits(), 32'd0);
        end
        random_words();
        for (int i = 0; i < 192; i++) fill_tab[i] = 8'd250;
        model_set();
        run_set(0, 1, -1, "oor_fill");
        check("oor_fill_done_pulses", 32'(r_ndone), 32'd1);
        check("oor_fill_fill_steps", 32'(r_nfs), 32'd48);
        compare_words("oor_fill");

        random_words();
        set_through();
        run_set(0, 0, 30, "rst_move");

        random_words();
        set_through();
        model_set();
        run_set(0, 0, -1, "after_rst");
        check("after_rst_done_cycle", 32'(r_done_cyc), 32'd162);
        compare_words("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_pixel_mover.md
# core_pixel_mover

Data-path stage driven by the `core_pixel` address generator for one 8x8 RGB pixel set (64 pixels, 192 bytes).
- Accepts 48 DMA words into a 192-byte input buffer.
- Copies all 64 pixels, one per cycle, from the input buffer to a 192-byte output buffer at rotated RGB byte addresses.
- Returns 48 words to DMA.
- Step strobes tell `core_pixel` when to advance each address stream.

## Interface
Parameters:
- none; set geometry is fixed: 192 bytes per buffer, 48 words, 64 pixels.

Ports:
- `I_HCLK` in 1: the single clock; all logic on its rising edge.
- `I_HRESET_N` in 1: reset, asynchronous assert, active-low.
- `I_START` in 1: starts one set transfer; sampled in IDLE only.
- `I_DMA_READY` in 1: DMA side is available; gates FILL and DRAIN transfers.
- `I_WDATA` in 32: fill word; byte `[7:0]` is the first byte.
- `I_WVALID` in 1: fill word valid.
- `O_WREADY` out 1: fill word accepted when high together with `I_WVALID`.
- `I_PIXEL_IN_ADDR0`..`I_PIXEL_IN_ADDR3` in 8 each: input-buffer byte addresses for fill bytes `[7:0]`..`[31:24]`.
- `I_PIXEL_IN_ADDRR`/`G`/`B` in 8 each: input-buffer read addresses for the current pixel.
- `I_PIXEL_OUT_ADDRR`/`G`/`B` in 8 each: output-buffer write addresses for the current pixel.
- `I_PIXEL_OUT_ADDR0`..`I_PIXEL_OUT_ADDR3` in 8 each: output-buffer byte addresses for drain bytes `[7:0]`..`[31:24]`.
- `O_RDATA` in/out: out 32; registered drain word.
- `O_RVALID` out 1: drain word valid.
- `I_RREADY` in 1: drain word consumed.
- `O_FILL_STEP` out 1: fill handshake occurred this cycle; `core_pixel` advances ADDR0..3.
- `O_MOVE_STEP` out 1: pixel moved this cycle; `core_pixel` advances RGB addresses.
- `O_DRAIN_STEP` out 1: drain register loaded this cycle; `core_pixel` advances OUT_ADDR0..3.
- `O_BUSY` out 1: state is not IDLE.
- `O_DONE` out 1: one-cycle pulse when the set is finished.

## Operation
FSM states: IDLE, FILL, MOVE, DRAIN, DONE.
- **IDLE**
  - `I_START`=1 → FILL; word and pixel counters cleared.
- **FILL**
  - `O_WREADY` = (state==FILL) & `I_DMA_READY`; combinational.
  - On `I_WVALID`&`O_WREADY`: `in_mem[I_PIXEL_IN_ADDRk]` ← byte k of `I_WDATA`; `fill_cnt`++; `O_FILL_STEP`=1 in the same cycle.
  - Handshake with `fill_cnt`==47 → MOVE.
- **MOVE**
  - Every cycle: `out_mem[OUT_ADDRR]` ← `in_mem[IN_ADDRR]`; same for G and B. `O_MOVE_STEP`=1; `pix_cnt`++.
  - No stall. Cycle with `pix_cnt`==63 → DRAIN.
- **DRAIN**
  - Load condition: (!`O_RVALID` | `I_RREADY`) & `I_DMA_READY` & (`load_cnt` < 48).
  - On load: `O_RDATA` ← {`out_mem[ADDR3]`, `[ADDR2]`, `[ADDR1]`, `[ADDR0]`}; `O_RVALID`=1; `O_DRAIN_STEP`=1; `load_cnt`++.
  - `O_RVALID`&`I_RREADY` with no load → `O_RVALID`=0.
  - 48th word accepted (`O_RVALID`&`I_RREADY`, `load_cnt`==48) → DONE.
- **DONE**
  - `O_DONE`=1 for one cycle → IDLE.
- **Address range**
  - Byte address ≥192: the write is dropped; a read returns 8'h00; counters still advance.
- **Write conflicts**
  - Duplicate write addresses in one cycle: the highest byte lane wins for fill; for move, B beats G beats R.
- **`I_START` outside IDLE**: ignored.
- **`I_WVALID` outside FILL**: ignored; `O_WREADY`=0.
- **Reset mid-operation**: FSM goes to IDLE asynchronously; counters and outputs clear; buffer contents are not reset and are undefined until refilled.

## Timing
- **Reset values**: `O_WREADY`=0, `O_RDATA`=0, `O_RVALID`=0, all `*_STEP`=0, `O_BUSY`=0, `O_DONE`=0.
- **Cycle counts** (I_DMA_READY, I_WVALID, I_RREADY held high):
  - `I_START` in cycle 0; FILL in cycles 1–48.
  - MOVE in cycles 49–112.
  - First `O_RVALID` in cycle 114; 48 consecutive drain words.
  - `O_DONE` in cycle 162.
- **Step strobes and addresses**:
  - Step strobes are combinational from state and handshake.
  - `core_pixel` must present the next address by the following cycle.
  - Addresses are sampled in the cycle of the strobe.
- **Read-after-write**: the MOVE read of `in_mem` sees all FILL writes; `out_mem` drain reads see all MOVE writes; there are no same-cycle RAW cases.
- **`O_RDATA`**: held stable while `O_RVALID`=1 & `I_RREADY`=0.

## Test plan
- **Through mode**:
  - Stimulus: linear addresses (fill 4k..4k+3, move in=out, drain 4k..4k+3); words 0x03020100 upward.
  - Required: drained words equal filled words; `O_DONE` in cycle 162.
- **90° pattern**:
  - Stimulus: fill pixel p with R=p, G=p+64, B=p+128; drive a transposed OUT_ADDRR/G/B sequence.
  - Required: the output buffer holds the transposed pixels, checked against a model.
- **Backpressure**:
  - Stimulus: toggle `I_DMA_READY`, `I_WVALID` and `I_RREADY` randomly.
  - Required: exactly 48 `O_FILL_STEP`, 64 `O_MOVE_STEP` and 48 `O_DRAIN_STEP`; `O_RDATA` stable while stalled; data equal to the through-mode result.
- **Out-of-range address**:
  - Stimulus: `I_PIXEL_OUT_ADDR0`=200 during drain.
  - Required: byte `[7:0]` of that word = 0x00.
  - Stimulus: fill address 250.
  - Required: no buffer byte changes.
- **Spurious inputs**:
  - Stimulus: `I_START` during MOVE.
  - Required: ignored; exactly one `O_DONE`.
  - Stimulus: `I_WVALID` in IDLE.
  - Required: `O_WREADY`=0; no write.
- **Reset mid-MOVE**:
  - Stimulus: assert `I_HRESET_N`=0 at pixel 30.
  - Required: all outputs are at reset values immediately; after release, a new `I_START` completes a full set correctly.
